mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between the execute stage and the write-back stage.
- Issues load/store requests to the data-memory port with a req/ready/rvalid handshake.
- Aligns load data and generates store byte lanes.
- Registers the result into the wb_* pipeline outputs consumed by write-back. Stalls upstream while a memory access is outstanding.

Parameters:
- MEM_TIMEOUT, 255: cycles a memory access may remain incomplete before it is aborted. Range 1..255; the counter is 8 bits.
- NOP_INST, 32'h0000_0013: instruction word presented on wb_inst for bubbles.

Ports:
- clk  in  1  single clock; all state rises on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_pc  in  32  PC of the presented instruction.
- ex_inst  in  32  instruction word.
- ex_wr_reg_en  in  1  instruction writes rd.
- ex_wr_reg_addr  in  5  rd.
- ex_alu_result  in  32  ALU result; this is the effective address for loads and stores.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store. ex_mem_rd and ex_mem_wr are never both 1.
- ex_mem_funct3  in  3  access size/sign (RV32I funct3).
- ex_store_data  in  32  rs2 value for stores.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {ex_alu_result[31:2], 2'b00}.
- dmem_wstrb  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load word.
- mem_stall  out  1  upstream must hold all ex_* stable while this is 1.
- mem_misalign  out  1  one-cycle pulse: a misaligned access was dropped.
- mem_err  out  1  one-cycle pulse: an access timed out.
- wb_pc  out  32  PC to write-back.
- wb_inst  out  32  instruction to write-back.
- wb_wr_reg_en  out  1  write enable to write-back.
- wb_wr_reg_addr  out  5  rd to write-back.
- wb_reg_wdata  out  32  write data to write-back.

Behaviour:
- Reset values (asynchronous, active-high):
  - wb_pc=0, wb_inst=NOP_INST, wb_wr_reg_en=0, wb_wr_reg_addr=0, wb_reg_wdata=0.
  - mem_misalign=0, mem_err=0.
  - state=IDLE, timeout counter=0.
  - dmem_req drops in the same cycle that rst asserts.
- State machine: states IDLE and WAIT_RESP.
- Non-memory op (ex_valid=1, ex_mem_rd=0, ex_mem_wr=0):
  - Latency 1.
  - wb_* loaded from ex_* on the next edge; wb_reg_wdata=ex_alu_result.
  - mem_stall=0.
- Memory op in IDLE:
  - dmem_req=1 combinationally, dmem_we=ex_mem_wr.
  - Store: completes in the cycle dmem_ready=1; stays in IDLE.
  - Load: dmem_ready=1 moves IDLE to WAIT_RESP.
- Load in WAIT_RESP:
  - dmem_req=0.
  - Completes in the cycle dmem_rvalid=1; returns to IDLE.
  - dmem_rvalid is ignored while in IDLE.
- Stall rule:
  - mem_stall=1 for every cycle a memory op is present and not completing.
  - mem_stall=0 in the completion cycle.
  - The wb_* registers take the result on that completion edge.
- Bubbles: while stalled, or when ex_valid=0, the next edge loads wb_wr_reg_en=0 and wb_inst=NOP_INST. wb_pc and wb_reg_wdata hold.
- rd=0: wb_wr_reg_en is forced to 0 whenever ex_wr_reg_addr=0.
- Misalignment: halfword access with addr[0]=1, or word access with addr[1:0]!=0:
  - no dmem_req and no stall;
  - bubble to write-back;
  - mem_misalign=1 for one cycle after the edge.
- Timeout:
  - The counter increments each stalled cycle and clears on completion or abort.
  - When the counter reaches MEM_TIMEOUT, the access is aborted: state goes to IDLE, a bubble goes to write-back, and mem_err pulses for 1 cycle.
  - The aborted instruction is consumed; mem_stall=0 in the abort cycle.
  - A late dmem_rvalid after an abort is ignored.
- Load extraction, with a = addr[1:0]:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: whole word.
  - Unsupported funct3 (011, 110, 111): treated as LW.
- Store lanes:
  - SB: wdata={4{byte}}, wstrb=4'b0001<<a.
  - SH: wdata={2{half}}, wstrb=4'b0011<<a.
  - SW: wdata=store data, wstrb=4'b1111.
  - dmem_wstrb=0 for loads.
- Simultaneous dmem_ready and dmem_rvalid in IDLE: ready is honoured, rvalid is ignored.
- Reset mid-access: an outstanding response is abandoned; state is IDLE after reset.

Decomposition:
- Shared package riscv_pkg:
  - funct3 encodings: LB=000, LH=001, LW=010, LBU=100, LHU=101 (SB/SH/SW share 000/001/010);
  - NOP_INST constant;
  - mem_state_t enum {IDLE, WAIT_RESP}.
- One combinational sub-module, mem_align, holds load extraction, store lane replication, wstrb generation and misalign detection.
- The FSM, timeout counter and wb_* registers stay in mem_stage.

Test Plan:
- ADD result 0x1234, rd=5, no memory op -> next cycle wb_wr_reg_en=1, wb_wr_reg_addr=5, wb_reg_wdata=0x1234; mem_stall never asserted.
- LB addr 0x103, dmem_ready in cycle 0, rvalid in cycle 2 with rdata 0x80FF_0000 -> mem_stall=1 for cycles 0..1; then wb_reg_wdata=0xFFFF_FF80.
- SH addr 0x202, data 0xABCD, dmem_ready held 0 for 3 cycles -> dmem_wstrb=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x200; stall 3 cycles; then wb_wr_reg_en=0.
- LW addr 0x105 -> no dmem_req, mem_misalign pulses once, wb bubble with wb_inst=0x0000_0013.
- LW with MEM_TIMEOUT=4, dmem_ready=1 but no rvalid -> mem_err pulse after 4 stall cycles; a later rvalid is ignored and write-back is unchanged.
- rst asserted during WAIT_RESP -> dmem_req=0 and all wb_* at reset values immediately; a subsequent rvalid is ignored; LHU addr 0x302 with rdata 0x8001_0000 after reset -> wb_reg_wdata=0x0000_8001.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 access encodings,
// the bubble instruction and the memory-access state type.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {IDLE, WAIT_RESP} mem_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

  // Stores reuse the load encodings; anything unrecognised is a word access.
  function automatic acc_size_t acc_size(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: acc_size = SZ_BYTE;
      F3_LH, F3_LHU: acc_size = SZ_HALF;
      F3_LW:         acc_size = SZ_WORD;
      default:       acc_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: request channel with ready, response channel with rvalid.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wstrb, wdata, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, wstrb, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_align.sv
// Byte-lane handling for the memory stage: load extraction, store lane
// replication, write strobes and misalignment detection.
module mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misalign
);

  acc_size_t   size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign size    = acc_size(funct3);
  assign ld_byte = rdata[{offset, 3'b000} +: 8];
  assign ld_half = offset[1] ? rdata[31:16] : rdata[15:0];

  // funct3[2] marks the unsigned load variants
  always_comb begin
    misalign  = 1'b0;
    wdata     = store_data;
    wstrb     = 4'b1111;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        wdata     = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << offset;
        load_data = funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        misalign  = offset[0];
        wdata     = {2{store_data[15:0]}};
        wstrb     = 4'b0011 << offset;
        load_data = funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: misalign = |offset;
    endcase
    if (!is_store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data-memory port, stalls upstream
// while an access is outstanding and registers results for write-back.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 255,
  parameter logic [31:0] NOP_INST    = riscv_pkg::NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [31:0]         ex_pc,
  input  logic [31:0]         ex_inst,
  input  logic                ex_wr_reg_en,
  input  logic [4:0]          ex_wr_reg_addr,
  input  logic [31:0]         ex_alu_result,
  input  logic                ex_mem_rd,
  input  logic                ex_mem_wr,
  input  logic [2:0]          ex_mem_funct3,
  input  logic [31:0]         ex_store_data,
  mem_stage_if.master         dmem,
  output logic                mem_stall,
  output logic                mem_misalign,
  output logic                mem_err,
  output logic [31:0]         wb_pc,
  output logic [31:0]         wb_inst,
  output logic                wb_wr_reg_en,
  output logic [4:0]          wb_wr_reg_addr,
  output logic [31:0]         wb_reg_wdata
);

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  mem_state_t  state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic        is_mem, misalign, mem_go, timed_out;
  logic        mem_done, abort, req_int, retire;
  logic [31:0] load_data;

  mem_align u_align (
    .funct3     (ex_mem_funct3),
    .offset     (ex_alu_result[1:0]),
    .is_store   (ex_mem_wr),
    .store_data (ex_store_data),
    .rdata      (dmem.rdata),
    .wdata      (dmem.wdata),
    .wstrb      (dmem.wstrb),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  assign is_mem    = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign mem_go    = is_mem & ~misalign;
  assign timed_out = (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= mem_stall ? tmo_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (mem_go && ex_mem_rd && dmem.ready && !timed_out) state_nxt = WAIT_RESP;
      WAIT_RESP: if (mem_done || abort) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A response arriving on the timeout cycle still completes the access.
  always_comb begin
    mem_done = 1'b0;
    abort    = 1'b0;
    req_int  = 1'b0;
    case (state)
      IDLE: begin
        req_int = mem_go;
        if (mem_go) begin
          if (ex_mem_wr && dmem.ready) mem_done = 1'b1;
          else if (timed_out)          abort    = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (dmem.rvalid)    mem_done = 1'b1;
        else if (timed_out) abort    = 1'b1;
      end
      default: ;
    endcase
    mem_stall = (mem_go || state == WAIT_RESP) && !mem_done && !abort;
  end

  assign dmem.req  = req_int & ~rst;
  assign dmem.we   = ex_mem_wr;
  assign dmem.addr = {ex_alu_result[31:2], 2'b00};
  assign retire    = (ex_valid & ~is_mem) | mem_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_pc          <= 32'd0;
      wb_inst        <= NOP_INST;
      wb_wr_reg_en   <= 1'b0;
      wb_wr_reg_addr <= 5'd0;
      wb_reg_wdata   <= 32'd0;
      mem_misalign   <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      mem_misalign <= is_mem & misalign;
      mem_err      <= abort;
      if (retire) begin
        wb_pc          <= ex_pc;
        wb_inst        <= ex_inst;
        wb_wr_reg_en   <= ex_wr_reg_en & (ex_wr_reg_addr != 5'd0);
        wb_wr_reg_addr <= ex_wr_reg_addr;
        wb_reg_wdata   <= ex_mem_rd ? load_data : ex_alu_result;
      end else begin
        wb_wr_reg_en <= 1'b0;
        wb_inst      <= NOP_INST;
      end
    end
  end

endmodule
